trace_beat_encoder: RTL and testbench

Captures one record per completed 6502 bus cycle (address, data, direction, opcode-fetch flag) into a small FIFO. Replays each record onto 12 GPIO pins as three 10-bit beats, qualified by a strobe whose falling edge marks valid data. Sits between the CPU bus and the GPIO pad mux; the external capture side samples data and first-beat flag on each strobe falling edge.

---
 rtl/trace_beat_encoder.sv | 182 ++++++++++++++++++
 tb/tb_trace_beat_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_beat_encoder.sv
// trace_beat_encoder: records completed 6502 bus cycles into a FIFO and replays
// each record on a 12-pin GPIO port as three 10-bit beats. A strobe qualifies
// every beat, and the payload is valid on the strobe's falling edge.
module trace_beat_encoder #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned STROBE_HALF     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        trace_en,
    input  logic        cpu_clken,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rnw,
    input  logic        cpu_sync,
    output logic [9:0]  gpio_beat,
    output logic        gpio_strobe,
    output logic        gpio_first,
    output logic        overflow
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned PHASE_W = 8;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STROBE_HALF - 1);

    typedef struct packed {
        logic        drop;
        logic        sync;
        logic        rnw;
        logic [7:0]  data;
        logic [15:0] addr;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    rec_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              drop_pending;

    state_t            state;
    logic [1:0]        beat_idx;
    logic [PHASE_W-1:0] phase;
    rec_t              cur;

    logic [PTR_W-1:0]  level_c;
    logic              empty_c;
    logic              full_c;
    logic              capture_c;
    logic              write_c;
    logic              drop_c;
    logic              pop_c;
    rec_t              wr_rec_c;
    rec_t              rd_rec_c;

    // Payload for one beat of a record; beat 2 carries the flags and high data nibble.
    function automatic logic [9:0] encode(input rec_t r, input logic [1:0] idx);
        logic [9:0] b;
        case (idx)
            2'd0:    b = r.addr[9:0];
            2'd1:    b = {r.data[3:0], r.addr[15:10]};
            default: b = {r.drop, 3'b000, r.sync, r.rnw, r.data[7:4]};
        endcase
        return b;
    endfunction

    // FIFO status, capture qualification and pop request.
    // A full FIFO drops the record even if the serializer pops on the same edge.
    always_comb begin
        level_c   = wr_ptr - rd_ptr;
        empty_c   = (level_c == '0);
        full_c    = (level_c == PTR_W'(DEPTH));
        capture_c = cpu_clken & trace_en;
        write_c   = capture_c & ~full_c;
        drop_c    = capture_c & full_c;

        wr_rec_c.drop = drop_pending;
        wr_rec_c.sync = cpu_sync;
        wr_rec_c.rnw  = cpu_rnw;
        wr_rec_c.data = cpu_rnw ? cpu_din : cpu_dout;
        wr_rec_c.addr = cpu_addr;

        rd_rec_c = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

        pop_c = ~empty_c &
                ((state == IDLE) |
                 ((state == LOW) && (phase == PHASE_LAST) && (beat_idx == 2'd2)));
    end

    // Record storage; occupancy lives entirely in the pointers.
    always_ff @(posedge clock) begin
        if (write_c) begin
            mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wr_rec_c;
        end
    end

    // FIFO pointers, pending-drop marker and sticky overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            drop_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (write_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop_c) begin
                drop_pending <= 1'b1;
                overflow     <= 1'b1;
            end else if (write_c) begin
                drop_pending <= 1'b0;
            end
        end
    end

    // Serializer: each beat is STROBE_HALF clocks high then STROBE_HALF clocks low.
    // Payload and first flag only ever change together with a rising strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            beat_idx    <= '0;
            phase       <= '0;
            cur         <= '0;
            gpio_beat   <= '0;
            gpio_strobe <= 1'b0;
            gpio_first  <= 1'b0;
        end else if (pop_c) begin
            cur         <= rd_rec_c;
            beat_idx    <= 2'd0;
            phase       <= '0;
            gpio_beat   <= encode(rd_rec_c, 2'd0);
            gpio_strobe <= 1'b1;
            gpio_first  <= 1'b1;
            state       <= HIGH;
        end else begin
            case (state)
                HIGH: begin
                    if (phase == PHASE_LAST) begin
                        phase       <= '0;
                        gpio_strobe <= 1'b0;
                        state       <= LOW;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                LOW: begin
                    if (phase == PHASE_LAST) begin
                        phase <= '0;
                        if (beat_idx != 2'd2) begin
                            beat_idx    <= beat_idx + 2'd1;
                            gpio_beat   <= encode(cur, beat_idx + 2'd1);
                            gpio_strobe <= 1'b1;
                            gpio_first  <= 1'b0;
                            state       <= HIGH;
                        end else begin
                            gpio_first <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                default: begin
                    gpio_strobe <= 1'b0;
                    gpio_first  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_beat_encoder.sv
// tb_trace_beat_encoder: directed table vectors, multi-cycle corner sequences and
// random traffic, all checked against a timeline model of captures and beats.
module tb_trace_beat_encoder;

    localparam int DEPTH = 16;
    localparam int SH    = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        trace_en;
    logic        cpu_clken;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    logic        cpu_sync;
    logic [9:0]  gpio_beat;
    logic        gpio_strobe;
    logic        gpio_first;
    logic        overflow;

    trace_beat_encoder #(.FIFO_DEPTH_LOG2(4), .STROBE_HALF(SH)) dut (
        .clock(clock), .reset_n(reset_n), .trace_en(trace_en), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .cpu_sync(cpu_sync), .gpio_beat(gpio_beat), .gpio_strobe(gpio_strobe),
        .gpio_first(gpio_first), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int data; int rnw; int sync; int drop; } mrec_t;
    typedef struct { int beat; int first; int fall; } exp_t;
    typedef struct {
        int addr; int din; int dout; bit rnw; bit sync; int b0; int b1; int b2;
    } vec_t;

    int     n_total = 0;
    int     n_pass  = 0;
    int     edge_n  = 0;
    int     free_at = 0;
    int     rise_edge = 0;
    bit     m_ovf  = 0;
    bit     m_drop = 0;
    bit     prev_strobe = 0;
    int     prev_beat = 0;
    int     prev_first = 0;
    mrec_t  mq[$];
    exp_t   exp_q[$];
    int     obs_beat[$];
    int     obs_first[$];
    vec_t   tbl[4];

    always @(posedge clock) edge_n++;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, expv, edge_n);
    endtask

    // Beat payloads straight from the field layout, using plain arithmetic.
    function automatic int enc(input mrec_t r, input int b);
        if (b == 0) return r.addr % 1024;
        if (b == 1) return (r.data % 16) * 64 + r.addr / 1024;
        return r.drop * 512 + r.sync * 32 + r.rnw * 16 + r.data / 16;
    endfunction

    // Compare what the pins show after each edge with the model's beat timeline.
    task automatic monitor();
        exp_t x;
        if (gpio_strobe && !prev_strobe) rise_edge = edge_n;
        if (gpio_strobe && prev_strobe) begin
            chk("beat_stable_high", gpio_beat, prev_beat);
            chk("first_stable_high", gpio_first, prev_first);
        end
        if (exp_q.size() != 0 && exp_q[0].fall < edge_n) begin
            chk("beat_late", edge_n, exp_q[0].fall);
            void'(exp_q.pop_front());
        end
        if (!gpio_strobe && prev_strobe) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("beat_payload", gpio_beat, x.beat);
                chk("beat_first", gpio_first, x.first);
                chk("beat_fall_edge", edge_n, x.fall);
                chk("strobe_high_width", edge_n - rise_edge, SH);
            end
            obs_beat.push_back(int'(gpio_beat));
            obs_first.push_back(int'(gpio_first));
        end
        chk("overflow", overflow, m_ovf);
        prev_strobe = gpio_strobe;
        prev_beat   = int'(gpio_beat);
        prev_first  = int'(gpio_first);
    endtask

    // Model one edge: the serializer takes a record whenever it is free and the
    // queue is non-empty; a record then occupies it for 6*SH clocks.
    task automatic step();
        int    e;
        bit    full;
        mrec_t r;
        e    = edge_n + 1;
        full = (mq.size() == DEPTH);
        if (mq.size() != 0 && e >= free_at) begin
            r = mq.pop_front();
            for (int b = 0; b < 3; b++)
                exp_q.push_back('{beat: enc(r, b), first: (b == 0) ? 1 : 0, fall: e + SH + 2 * SH * b});
            free_at = e + 6 * SH;
        end
        if (cpu_clken && trace_en) begin
            if (full) begin
                m_ovf  = 1;
                m_drop = 1;
            end else begin
                r.addr = int'(cpu_addr);
                r.data = cpu_rnw ? int'(cpu_din) : int'(cpu_dout);
                r.rnw  = int'(cpu_rnw);
                r.sync = int'(cpu_sync);
                r.drop = int'(m_drop);
                m_drop = 0;
                mq.push_back(r);
            end
        end
        @(posedge clock);
        @(negedge clock);
        monitor();
    endtask

    task automatic tick(input bit ck, input int a, input int di, input int dv, input bit rnw, input bit sy);
        cpu_clken = ck;
        cpu_addr  = 16'(a);
        cpu_din   = 8'(di);
        cpu_dout  = 8'(dv);
        cpu_rnw   = rnw;
        cpu_sync  = sy;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            idle(1);
            n++;
        end
        chk("drain_bound", n < 2000, 1);
        idle(2 * SH + 2);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        free_at = 0;
        m_ovf = 0;
        m_drop = 0;
        prev_strobe = 0;
    endtask

    initial begin
        int base;
        int n;
        tbl[0] = '{addr: 'hFFFC, din: 'h12, dout: 'h00, rnw: 1, sync: 0, b0: 'h3FC, b1: 'h0BF, b2: 'h011};
        tbl[1] = '{addr: 'h0200, din: 'h00, dout: 'hA5, rnw: 0, sync: 1, b0: 'h200, b1: 'h140, b2: 'h02A};
        tbl[2] = '{addr: 'h1234, din: 'h5A, dout: 'hFF, rnw: 1, sync: 1, b0: 'h234, b1: 'h284, b2: 'h035};
        tbl[3] = '{addr: 'hABCD, din: 'h77, dout: 'h3C, rnw: 0, sync: 0, b0: 'h3CD, b1: 'h32A, b2: 'h003};

        reset_n = 0; trace_en = 1; cpu_clken = 0; cpu_addr = '0;
        cpu_din = '0; cpu_dout = '0; cpu_rnw = 0; cpu_sync = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_beat", gpio_beat, 0);
        chk("rst_strobe", gpio_strobe, 0);
        chk("rst_first", gpio_first, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1;

        // Single records from the table: latency, payloads, idle hold.
        for (int i = 0; i < 4; i++) begin
            base = obs_beat.size();
            tick(1'b1, tbl[i].addr, tbl[i].din, tbl[i].dout, tbl[i].rnw, tbl[i].sync);
            chk("lat_strobe_n1", gpio_strobe, 0);
            idle(1);
            chk("lat_strobe_n2", gpio_strobe, 1);
            chk("lat_first_n2", gpio_first, 1);
            chk("lat_beat_n2", gpio_beat, tbl[i].b0);
            drain();
            chk("tbl_count", obs_beat.size() - base, 3);
            if (obs_beat.size() - base == 3) begin
                chk("tbl_b0", obs_beat[base], tbl[i].b0);
                chk("tbl_b1", obs_beat[base + 1], tbl[i].b1);
                chk("tbl_b2", obs_beat[base + 2], tbl[i].b2);
            end
            chk("idle_strobe", gpio_strobe, 0);
            chk("idle_first", gpio_first, 0);
            chk("idle_hold_beat", gpio_beat, tbl[i].b2);
        end

        // Two captures one clock apart: six beats, first flag on beats 0 and 3.
        base = obs_beat.size();
        tick(1'b1, 'h1111, 'h22, 0, 1'b1, 1'b0);
        tick(1'b1, 'h3333, 0, 'h44, 1'b0, 1'b1);
        drain();
        chk("b2b_beats", obs_beat.size() - base, 6);
        if (obs_beat.size() - base == 6)
            for (int i = 0; i < 6; i++) chk("b2b_first", obs_first[base + i], (i % 3 == 0) ? 1 : 0);

        // Queue three, disable capture, pulse clken: exactly three records drain.
        base = obs_beat.size();
        for (int i = 0; i < 3; i++) tick(1'b1, 'h0100 + i, 'h10 + i, 0, 1'b1, 1'b0);
        trace_en = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 'h0F00 + i, 'h99, 'h99, 1'b1, 1'b1);
        drain();
        trace_en = 1;
        chk("disable_beats", obs_beat.size() - base, 9);

        // 20 captures on consecutive clocks. The first is popped one edge after
        // capture and the second twelve clocks later, so 18 are kept and 2 dropped.
        base = obs_beat.size();
        for (int i = 0; i < 20; i++) tick(1'b1, 'h8000 + i * 'h101, $urandom_range(0, 255), 0, 1'b1, 1'b0);
        chk("burst_overflow", overflow, 1);
        drain();
        chk("burst_records", obs_beat.size() - base, 54);
        for (int i = base + 2; i < obs_beat.size(); i += 3) chk("burst_no_drop_bit", obs_beat[i] / 512, 0);
        base = obs_beat.size();
        tick(1'b1, 'h0042, 0, 'h5C, 1'b0, 1'b0);
        drain();
        chk("after_drop_count", obs_beat.size() - base, 3);
        if (obs_beat.size() - base == 3) chk("after_drop_bit9", obs_beat[base + 2] / 512, 1);
        chk("overflow_sticky", overflow, 1);

        // Reset mid-record during beat 1, then a clean record afterwards.
        base = obs_beat.size();
        tick(1'b1, 'h4321, 'h9E, 0, 1'b1, 1'b0);
        n = 0;
        while (obs_beat.size() == base && n < 50) begin idle(1); n++; end
        chk("reset_wait_bound", n < 50, 1);
        idle(SH + 1);
        chk("in_beat1_strobe", gpio_strobe, 1);
        reset_n = 0;
        #1;
        chk("async_rst_beat", gpio_beat, 0);
        chk("async_rst_strobe", gpio_strobe, 0);
        chk("async_rst_first", gpio_first, 0);
        chk("async_rst_overflow", overflow, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("post_rst_quiet", gpio_strobe, 0);
        end
        base = obs_beat.size();
        tick(1'b1, 'h0777, 'h3B, 0, 1'b1, 1'b1);
        idle(1);
        chk("post_rst_first", gpio_first, 1);
        chk("post_rst_beat0", gpio_beat, 'h377);
        drain();
        chk("post_rst_beats", obs_beat.size() - base, 3);

        // Random traffic, fast enough to overflow at times.
        for (int i = 0; i < 800; i++) begin
            trace_en = ($urandom_range(0, 15) != 0);
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 65535), $urandom_range(0, 255),
                 $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        trace_en = 1;
        drain();
        chk("rand_idle_strobe", gpio_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
